// File: rtl/mult_datapath_if.sv
// Bus between the add-shift multiplier control FSM (master) and its datapath (slave).
// Product_Valid is a level "valid" with no ready: it rises once the product is
// complete and holds until the next Load_B/Clear_AX, so the consumer samples at will.
interface mult_datapath_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] S;
  logic             Load_B;
  logic             Clear_AX;
  logic             Yes_Add;
  logic             Yes_Sub;
  logic             Shift_En;
  logic             Mval;
  logic             Xval;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Product_Valid;
  logic             Seq_Err;

  modport master (
    output S, Load_B, Clear_AX, Yes_Add, Yes_Sub, Shift_En,
    input  Mval, Xval, Aval, Bval, Product_Valid, Seq_Err
  );

  modport slave (
    input  S, Load_B, Clear_AX, Yes_Add, Yes_Sub, Shift_En,
    output Mval, Xval, Aval, Bval, Product_Valid, Seq_Err
  );
endinterface

// File: rtl/mult_datapath.sv
// X:A:B register datapath for the signed add-shift multiplier, with a shift
// counter and a sticky flag for controller sequencing errors.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  mult_datapath_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pv_q, pv_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum;

  assign a_ext = {a_q[WIDTH-1], a_q};
  assign s_ext = {bus.S[WIDTH-1], bus.S};

  // Both operands are sign-extended by one bit so sum[WIDTH] is the true sign.
  always_comb begin
    if (bus.Yes_Sub) sum = a_ext + ~s_ext + (WIDTH+1)'(1);
    else             sum = a_ext + s_ext;
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    x_d   = x_q;
    cnt_d = cnt_q;
    pv_d  = pv_q;
    err_d = err_q;
    if (bus.Load_B) begin
      b_d   = bus.S;
      a_d   = '0;
      x_d   = 1'b0;
      cnt_d = '0;
      pv_d  = 1'b0;
      err_d = 1'b0;
    end else if (bus.Clear_AX) begin
      a_d   = '0;
      x_d   = 1'b0;
      cnt_d = '0;
      pv_d  = 1'b0;
      err_d = 1'b0;
    end else if (bus.Yes_Add && bus.Yes_Sub) begin
      err_d = 1'b1;
    end else if (bus.Yes_Add || bus.Yes_Sub) begin
      a_d = sum[WIDTH-1:0];
      x_d = sum[WIDTH];
      if (bus.Shift_En) err_d = 1'b1;
    end else if (bus.Shift_En) begin
      if (cnt_q < CNT_MAX) begin
        a_d   = {x_q, a_q[WIDTH-1:1]};
        b_d   = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CNT_MAX) pv_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      cnt_q <= '0;
      pv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      err_q <= err_d;
    end
  end

  assign bus.Mval          = b_q[0];
  assign bus.Xval          = x_q;
  assign bus.Aval          = a_q;
  assign bus.Bval          = b_q;
  assign bus.Product_Valid = pv_q;
  assign bus.Seq_Err       = err_q;
endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: randomized and directed multiplies against an
// arithmetic product model, plus reset, overshift, conflict and priority cases.
module tb_mult_datapath;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [2*W:0] exp_q[$];
  logic         pv_prev = 1'b0;

  mult_datapath_if #(.WIDTH(W)) bus ();

  mult_datapath #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each rising Product_Valid presents a finished product.
  always @(negedge clk) begin
    if (rst) begin
      pv_prev <= 1'b0;
    end else begin
      if (bus.Product_Valid && !pv_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL product_unexpected: got 0x%0h with empty expected queue",
                   {bus.Xval, bus.Aval, bus.Bval});
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          if ({bus.Xval, bus.Aval, bus.Bval} !== e) begin
            failures++;
            $display("FAIL product: got X:A:B=0x%0h expected 0x%0h",
                     {bus.Xval, bus.Aval, bus.Bval}, e);
          end
        end
      end
      pv_prev <= bus.Product_Valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic ld, input logic clr, input logic ad, input logic sb,
                    input logic sh, input logic [W-1:0] s);
    bus.S        = s;
    bus.Load_B   = ld;
    bus.Clear_AX = clr;
    bus.Yes_Add  = ad;
    bus.Yes_Sub  = sb;
    bus.Shift_En = sh;
    @(posedge clk);
    #1;
    bus.Load_B   = 1'b0;
    bus.Clear_AX = 1'b0;
    bus.Yes_Add  = 1'b0;
    bus.Yes_Sub  = 1'b0;
    bus.Shift_En = 1'b0;
  endtask

  // Controller sequence; expected X:A:B is the sign-extended signed product.
  task automatic run_mult(input logic [W-1:0] mplier, input logic [W-1:0] mcand);
    int               p;
    logic [2*W-1:0]   p16;
    p   = int'($signed(mplier)) * int'($signed(mcand));
    p16 = p[2*W-1:0];
    exp_q.push_back({p16[2*W-1], p16});
    op(1, 0, 0, 0, 0, mplier);
    op(0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < W; i++) begin
      check($sformatf("mval_bit%0d", i), 32'(bus.Mval), 32'(mplier[i]));
      if (mplier[i]) op(0, 0, (i < W-1), (i == W-1), 0, mcand);
      else           op(0, 0, 0, 0, 0, mcand);
      if (i == W-1) check("pv_before_last_shift", 32'(bus.Product_Valid), 0);
      op(0, 0, 0, 0, 1, mcand);
    end
    check("pv_after_last_shift", 32'(bus.Product_Valid), 1);
    check("seq_err_clean_run", 32'(bus.Seq_Err), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.S = '0; bus.Load_B = 0; bus.Clear_AX = 0;
    bus.Yes_Add = 0; bus.Yes_Sub = 0; bus.Shift_En = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.Mval, bus.Xval, bus.Aval, bus.Bval, bus.Product_Valid, bus.Seq_Err}, 0);
    rst = 1'b0;

    // Basic multiply (-3)*7 and overshift
    run_mult(8'hFD, 8'h07);
    check("basic_ab", {bus.Aval, bus.Bval}, 32'h0000FFEB);
    check("basic_x", 32'(bus.Xval), 1);
    op(0, 0, 0, 0, 1, 8'h00);
    check("overshift_ab", {bus.Aval, bus.Bval}, 32'h0000FFEB);
    check("overshift_err", 32'(bus.Seq_Err), 1);
    check("overshift_pv_hold", 32'(bus.Product_Valid), 1);
    op(0, 1, 0, 0, 0, 8'h00);
    check("clear_err", 32'(bus.Seq_Err), 0);
    check("clear_pv", 32'(bus.Product_Valid), 0);
    check("clear_b_kept", 32'(bus.Bval), 32'hEB);
    check("clear_ax", {bus.Xval, bus.Aval}, 0);

    // Corner (-128)*(-128)
    run_mult(8'h80, 8'h80);
    check("corner_ab", {bus.Aval, bus.Bval}, 32'h00004000);
    check("corner_x", 32'(bus.Xval), 0);

    // Conflict: simultaneous add/sub, then add with shift
    op(1, 0, 0, 0, 0, 8'h00);
    op(0, 0, 1, 0, 0, 8'h10);
    check("conflict_setup_a", 32'(bus.Aval), 32'h10);
    op(0, 0, 1, 1, 0, 8'h05);
    check("conflict_a_hold", 32'(bus.Aval), 32'h10);
    check("conflict_err", 32'(bus.Seq_Err), 1);
    op(0, 0, 1, 1, 1, 8'h05);
    check("conflict_shift_dropped", {bus.Aval, bus.Bval}, 32'h1000);
    op(0, 0, 1, 0, 1, 8'h05);
    check("add_shift_a", 32'(bus.Aval), 32'h15);
    check("add_shift_b", 32'(bus.Bval), 0);
    check("add_shift_err", 32'(bus.Seq_Err), 1);
    // Count must still be 0: Product_Valid appears only on the eighth shift.
    exp_q.push_back({1'b0, 16'h0015});
    for (int i = 0; i < W; i++) begin
      if (i == W-1) check("count_pv_after_7", 32'(bus.Product_Valid), 0);
      op(0, 0, 0, 0, 1, 8'h00);
    end
    check("count_pv_after_8", 32'(bus.Product_Valid), 1);
    check("err_sticky", 32'(bus.Seq_Err), 1);

    // Priority: Load_B over Clear_AX over Yes_Add
    op(1, 1, 1, 0, 0, 8'h3C);
    check("prio_b", 32'(bus.Bval), 32'h3C);
    check("prio_ax", {bus.Xval, bus.Aval}, 0);
    check("prio_err_cleared", 32'(bus.Seq_Err), 0);
    check("prio_mval", 32'(bus.Mval), 0);

    // Randomized multiplies
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] m, c;
      m = W'($urandom_range(0, 255));
      c = W'($urandom_range(0, 255));
      if (n == 0) m = 8'h7F;
      if (n == 1) c = 8'h80;
      run_mult(m, c);
    end

    // Asynchronous reset mid-operation
    op(1, 0, 0, 0, 0, 8'h33);
    op(0, 1, 0, 0, 0, 8'h00);
    op(0, 0, 1, 0, 0, 8'h5A);
    check("pre_reset_ab", {bus.Aval, bus.Bval}, 32'h5A33);
    #3 rst = 1'b1;
    #2;
    check("async_reset_outputs",
          {bus.Mval, bus.Xval, bus.Aval, bus.Bval, bus.Product_Valid, bus.Seq_Err}, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_hold", {bus.Aval, bus.Bval}, 0);

    repeat (2) @(posedge clk);
    check("expected_queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
Register/arithmetic datapath for the 8-bit signed add-shift multiplier. It is driven cycle-by-cycle by the multiplier control FSM, which issues Load_B, Clear_AX, Yes_Add, Yes_Sub and Shift_En. The block returns Mval (the current multiplier LSB) to the FSM and holds the X:A:B product register that feeds the hex display stage. It also includes a shift counter and sequence checker so that misuse by the controller is flagged in hardware.

Parameters:
WIDTH, 8, operand width in bits; the product is 2*WIDTH bits.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
S  input  WIDTH  switch operand: multiplier on Load_B, multiplicand during add/sub.
Load_B  input  1  load S into B; clear A, X, counter and flags.
Clear_AX  input  1  clear A, X, counter and flags; B unchanged.
Yes_Add  input  1  A <= A + S, signed.
Yes_Sub  input  1  A <= A - S, signed.
Shift_En  input  1  arithmetic right shift of X:A:B.
Mval  output  1  B[0], combinational.
Xval  output  1  sign-extension flip-flop X.
Aval  output  WIDTH  register A, upper product half.
Bval  output  WIDTH  register B, lower product half.
Product_Valid  output  1  registered; high once WIDTH shifts are done since the last clear.
Seq_Err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, any time, including mid-operation): A=0, B=0, X=0, shift count=0, Product_Valid=0, Seq_Err=0. Mval therefore reads 0.
- All other updates occur on the rising edge of Clk.
- Priority, highest first: Load_B, Clear_AX, Yes_Add/Yes_Sub, Shift_En. Only the highest active operation executes in a cycle.
- Load_B: B<=S; A<=0; X<=0; count<=0; Product_Valid<=0; Seq_Err<=0.
- Clear_AX: A<=0; X<=0; count<=0; Product_Valid<=0; Seq_Err<=0; B holds.
- Add: 9-bit sum = {A[W-1],A} + {S[W-1],S}. A<=sum[W-1:0]; X<=sum[W]; carry-out is discarded. B and count hold.
- Sub: 9-bit sum = {A[W-1],A} + ~{S[W-1],S} + 1. A and X update as for Add.
- Shift (only when count<WIDTH): X holds; A<={X,A[W-1:1]}; B<={A[0],B[W-1:1]}; count<=count+1.
- Shift when count==WIDTH: registers hold; Seq_Err<=1.
- Product_Valid<=1 on the cycle count becomes WIDTH. It stays high until Load_B, Clear_AX or Reset.
- Yes_Add and Yes_Sub both high: no arithmetic; Seq_Err<=1. A Shift_En in the same cycle is also suppressed.
- Add or Sub together with Shift_En: the arithmetic executes, the shift is dropped, Seq_Err<=1.
- Seq_Err is sticky. Only Load_B, Clear_AX or Reset clears it.
- No operation active: all registers hold.
- Counter width is clog2(WIDTH+1) bits and never wraps.
- Expected controller sequence per bit i=0..WIDTH-2: add-if-Mval cycle, then shift cycle. The final bit uses a sub-if-Mval cycle, then a shift cycle. Latency from Clear_AX to Product_Valid is therefore 2*WIDTH cycles at the minimum.
- Result: {Aval,Bval} is the signed 2*WIDTH-bit product.

Test Plan:
- Reset mid-run: assert Reset asynchronously between clock edges with A=0x5A, B=0x33 -> all outputs 0 immediately, with no clock edge required.
- Basic multiply: S=0xFD, Load_B; Clear_AX; S=0x07; run the 7 add/shift pairs plus the sub/shift pair, gated by Mval -> {A,B}=0xFFEB (-21), X=1, Product_Valid=1 after the 16th operation cycle.
- Corner operands: B=0x80, S=0x80 ((-128)*(-128)) -> only the final sub fires; result {A,B}=0x4000, X=0.
- Overshift: after Product_Valid, pulse Shift_En -> A and B unchanged, Seq_Err=1. Then Clear_AX -> Seq_Err=0, Product_Valid=0, B retained.
- Conflict: A=0x10, S=0x05, Yes_Add and Yes_Sub high together -> A stays 0x10, Seq_Err=1. Then Yes_Add with Shift_En -> A=0x15, no shift, count unchanged.
- Priority: Load_B, Clear_AX and Yes_Add high together with S=0x3C -> B=0x3C, A=0, X=0, no add performed.
